// File: rtl/uart_pkg.sv
// Shared UART definitions: byte type, data width and default FIFO depth.
// Imported by the receiver, transmitter and their buffers.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage: synchronous write, registered read.
// Only the read register is reset; the array itself is not.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  uart_byte_t        i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output uart_byte_t        o_rdata
);

    uart_byte_t r_mem [DEPTH];
    uart_byte_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read sees the pre-write contents when both hit one slot (full push+pop).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side circular FIFO with registered pop and sticky overrun.
// Optional threshold interrupt: define UART_RX_FIFO_THRESHOLD_IRQ_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rxValid,
    input  uart_byte_t      rxData,
    input  logic            rdReq,
    input  logic            overrunClear,
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
    input  logic [ADDR_W:0] irqThreshold,
    output logic            rxIrq,
`endif
    output uart_byte_t      rdData,
    output logic            rdValid,
    output logic            empty,
    output logic            full,
    output logic [ADDR_W:0] count,
    output logic            overrun
);

    localparam logic [ADDR_W:0] PTR_INC = (ADDR_W+1)'(1);

    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_rd_valid;
    logic            r_overrun;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic [ADDR_W:0] w_wr_ptr_nxt;
    logic [ADDR_W:0] w_rd_ptr_nxt;

    // Extra wrap bit distinguishes full from empty when indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);

    assign w_pop  = rdReq && !w_empty;
    assign w_push = rxValid && (!w_full || w_pop);
    assign w_drop = rxValid && w_full && !w_pop;

    assign w_wr_ptr_nxt = w_push ? r_wr_ptr + PTR_INC : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + PTR_INC : r_rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_rd_valid <= w_pop;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrunClear) begin
            r_overrun <= 1'b0;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (rxData),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (rdData)
    );

`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
    logic            r_rx_irq;
    logic [ADDR_W:0] w_count_nxt;

    assign w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_irq <= 1'b0;
        end else begin
            r_rx_irq <= (w_count_nxt >= irqThreshold) &&
                        (irqThreshold != '0);
        end
    end

    assign rxIrq = r_rx_irq;
`endif

    assign rdValid = r_rd_valid;
    assign empty   = w_empty;
    assign full    = w_full;
    assign count   = r_wr_ptr - r_rd_ptr;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16).
// Define UART_RX_FIFO_THRESHOLD_IRQ_EN to also exercise rxIrq.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxValid;
    logic [7:0] rxData;
    logic       rdReq;
    logic       overrunClear;
    logic [7:0] rdData;
    logic       rdValid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
    logic [4:0] irqThreshold;
    logic       rxIrq;
`endif

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .rxValid      (rxValid),
        .rxData       (rxData),
        .rdReq        (rdReq),
        .overrunClear (overrunClear),
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
        .irqThreshold (irqThreshold),
        .rxIrq        (rxIrq),
`endif
        .rdData       (rdData),
        .rdValid      (rdValid),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        rxValid = 1'b1;
        rxData  = d;
        tick();
        rxValid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        if (rdValid !== 1'b0) begin failures++; $display("FAIL reset_rdValid got=%b exp=0", rdValid); end
        if (rdData !== 8'h00) begin failures++; $display("FAIL reset_rdData got=%h exp=00", rdData); end
    endtask

    task automatic test_two_bytes();
        push(8'hA5);
        push(8'h3C);
        checks++;
        if (count !== 5'd2) begin failures++; $display("FAIL two_count got=%0d exp=2", count); end
        rdReq = 1'b1;
        tick();
        checks += 2;
        if (rdValid !== 1'b1) begin failures++; $display("FAIL two_v0 got=%b exp=1", rdValid); end
        if (rdData !== 8'hA5) begin failures++; $display("FAIL two_d0 got=%h exp=a5", rdData); end
        tick();
        rdReq = 1'b0;
        checks += 3;
        if (rdValid !== 1'b1) begin failures++; $display("FAIL two_v1 got=%b exp=1", rdValid); end
        if (rdData !== 8'h3C) begin failures++; $display("FAIL two_d1 got=%h exp=3c", rdData); end
        if (empty !== 1'b1) begin failures++; $display("FAIL two_empty got=%b exp=1", empty); end
        tick();
        checks++;
        if (rdValid !== 1'b0) begin failures++; $display("FAIL two_vdrop got=%b exp=0", rdValid); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
        end
        checks += 3;
        if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
        if (count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", count); end
        if (overrun !== 1'b0) begin failures++; $display("FAIL fill_ovr0 got=%b exp=0", overrun); end
        push(8'h10);
        checks += 2;
        if (overrun !== 1'b1) begin failures++; $display("FAIL fill_ovr1 got=%b exp=1", overrun); end
        if (count !== 5'd16) begin failures++; $display("FAIL fill_count17 got=%0d exp=16", count); end
        rdReq = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks += 2;
            if (rdData !== 8'(i)) begin failures++; $display("FAIL fill_pop%0d got=%h exp=%h", i, rdData, 8'(i)); end
            if (rdValid !== 1'b1) begin failures++; $display("FAIL fill_popv%0d got=%b exp=1", i, rdValid); end
        end
        rdReq = 1'b0;
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL fill_empty got=%b exp=1", empty); end
        overrunClear = 1'b1;
        tick();
        overrunClear = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL fill_clr got=%b exp=0", overrun); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 16; i++) begin
            push(8'h20 + 8'(i));
        end
        rxValid = 1'b1;
        rxData  = 8'h77;
        rdReq   = 1'b1;
        tick();
        rxValid = 1'b0;
        checks += 4;
        if (rdData !== 8'h20) begin failures++; $display("FAIL ppf_d got=%h exp=20", rdData); end
        if (count !== 5'd16) begin failures++; $display("FAIL ppf_count got=%0d exp=16", count); end
        if (overrun !== 1'b0) begin failures++; $display("FAIL ppf_ovr got=%b exp=0", overrun); end
        if (full !== 1'b1) begin failures++; $display("FAIL ppf_full got=%b exp=1", full); end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++;
            if (rdData !== 8'h20 + 8'(i)) begin failures++; $display("FAIL ppf_pop%0d got=%h exp=%h", i, rdData, 8'h20 + 8'(i)); end
        end
        tick();
        rdReq = 1'b0;
        checks += 2;
        if (rdData !== 8'h77) begin failures++; $display("FAIL ppf_last got=%h exp=77", rdData); end
        if (empty !== 1'b1) begin failures++; $display("FAIL ppf_empty got=%b exp=1", empty); end
    endtask

    task automatic test_empty_read();
        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        checks += 4;
        if (rdValid !== 1'b0) begin failures++; $display("FAIL er_v got=%b exp=0", rdValid); end
        if (rdData !== 8'h77) begin failures++; $display("FAIL er_d got=%h exp=77", rdData); end
        if (count !== 5'd0) begin failures++; $display("FAIL er_count got=%0d exp=0", count); end
        if (overrun !== 1'b0) begin failures++; $display("FAIL er_ovr got=%b exp=0", overrun); end
        rxValid = 1'b1;
        rxData  = 8'h55;
        rdReq   = 1'b1;
        tick();
        rxValid = 1'b0;
        rdReq   = 1'b0;
        checks += 3;
        if (count !== 5'd1) begin failures++; $display("FAIL epp_count got=%0d exp=1", count); end
        if (rdValid !== 1'b0) begin failures++; $display("FAIL epp_v got=%b exp=0", rdValid); end
        if (empty !== 1'b0) begin failures++; $display("FAIL epp_empty got=%b exp=0", empty); end
        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        checks += 2;
        if (rdData !== 8'h55) begin failures++; $display("FAIL epp_d got=%h exp=55", rdData); end
        if (rdValid !== 1'b1) begin failures++; $display("FAIL epp_v2 got=%b exp=1", rdValid); end
    endtask

    task automatic test_overrun_clear();
        for (int i = 0; i < 16; i++) begin
            push(8'h40 + 8'(i));
        end
        rxValid      = 1'b1;
        rxData       = 8'h99;
        overrunClear = 1'b1;
        tick();
        rxValid      = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL oc_setwins got=%b exp=1", overrun); end
        tick();
        overrunClear = 1'b0;
        checks += 2;
        if (overrun !== 1'b0) begin failures++; $display("FAIL oc_clear got=%b exp=0", overrun); end
        if (count !== 5'd16) begin failures++; $display("FAIL oc_count got=%0d exp=16", count); end
        #2;
        reset = 1'b1;
        #1;
        checks += 3;
        if (count !== 5'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        if (empty !== 1'b1) begin failures++; $display("FAIL mid_rst_empty got=%b exp=1", empty); end
        if (rdData !== 8'h00) begin failures++; $display("FAIL mid_rst_d got=%h exp=00", rdData); end
        tick();
        reset = 1'b0;
        tick();
    endtask

`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
    task automatic test_irq();
        irqThreshold = 5'd4;
        for (int i = 0; i < 3; i++) begin
            push(8'(i));
        end
        checks++;
        if (rxIrq !== 1'b0) begin failures++; $display("FAIL irq_below got=%b exp=0", rxIrq); end
        push(8'h03);
        checks++;
        if (rxIrq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", rxIrq); end
        rdReq = 1'b1;
        tick();
        rdReq = 1'b0;
        checks++;
        if (rxIrq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", rxIrq); end
        push(8'h04);
        checks++;
        if (rxIrq !== 1'b1) begin failures++; $display("FAIL irq_rise2 got=%b exp=1", rxIrq); end
        #2;
        reset = 1'b1;
        #1;
        checks += 2;
        if (rxIrq !== 1'b0) begin failures++; $display("FAIL irq_rst got=%b exp=0", rxIrq); end
        if (count !== 5'd0) begin failures++; $display("FAIL irq_rst_count got=%0d exp=0", count); end
        tick();
        reset = 1'b0;
        irqThreshold = 5'd0;
        tick();
    endtask
`endif

    initial begin
        reset        = 1'b1;
        rxValid      = 1'b0;
        rxData       = 8'h00;
        rdReq        = 1'b0;
        overrunClear = 1'b0;
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
        irqThreshold = 5'd0;
`endif
        test_reset();
        test_two_bytes();
        test_fill_overrun();
        test_push_pop_full();
        test_empty_read();
        test_overrun_clear();
`ifdef UART_RX_FIFO_THRESHOLD_IRQ_EN
        test_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
